// File: rtl/mc_io_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO map, STATUS
// bit positions and the UART transmitter state type.
package mc_io_pkg;

  localparam logic [31:0] MMIO_LED    = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_SW     = 32'hFFFF_0004;
  localparam logic [31:0] MMIO_TIMER  = 32'hFFFF_0008;
  localparam logic [31:0] MMIO_UART   = 32'hFFFF_000C;
  localparam logic [31:0] MMIO_STATUS = 32'hFFFF_0010;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Word-granular address compare; byte offset bits never take part in decode.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/mc_data_mem_io_uart_tx.sv
// FIFO-buffered 8N1 serial transmitter: byte FIFO, baud counter and
// serializer. tx is registered and idles high.
module uart_tx
  import mc_io_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = PW + 1;
  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          pop;
  logic          push_ok;

  uart_state_t   state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          baud_last;

  assign full      = (count_q == NW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign busy      = (state_q != IDLE);
  assign tx        = tx_q;
  assign baud_last = (baud_q == CW'(BAUD_DIV - 1));

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  always_comb begin
    pop      = (state_q == IDLE) && !empty;
    push_ok  = push && (!full || pop);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + NW'(push_ok) - NW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shreg_q <= fifo_q[rd_ptr_q];
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shreg_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/mc_data_mem_io.sv
// Data-side memory subsystem for the multicycle core: word RAM plus MMIO
// (LED, switches, cycle timer, UART TX) behind a registered read port.
module mc_data_mem_io
  import mc_io_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int unsigned DMEM_WORDS = 1024,
  parameter string       DMEM_INIT  = "",
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        uart_tx
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
  localparam int unsigned AW       = $clog2(DMEM_WORDS);

  logic [31:0]   mem_q [DMEM_WORDS];
  logic [29:0]   ram_off;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;

  logic hit_led, hit_sw, hit_timer, hit_uart, hit_status;
  logic rd_en, we;
  logic push, drop;
  logic fifo_full, fifo_empty, tx_busy;
  logic unused_addr_bits;

  logic [31:0] rdata_q, rdata_d, rdata_mux;
  logic [15:0] led_q, led_d;
  logic [15:0] sw_meta_q, sw_meta_d;
  logic [15:0] sw_sync_q, sw_sync_d;
  logic [31:0] timer_q, timer_d;
  logic        overflow_q, overflow_d;

  assign unused_addr_bits = ^dAddress[1:0];

  // Unsigned wrap makes addresses below the base land far out of range.
  assign ram_off    = dAddress[31:2] - DMEM_BASE[31:2];
  assign ram_hit    = (ram_off < 30'(DMEM_WORDS));
  assign ram_idx    = ram_off[AW-1:0];

  assign hit_led    = word_match(dAddress, MMIO_LED);
  assign hit_sw     = word_match(dAddress, MMIO_SW);
  assign hit_timer  = word_match(dAddress, MMIO_TIMER);
  assign hit_uart   = word_match(dAddress, MMIO_UART);
  assign hit_status = word_match(dAddress, MMIO_STATUS);

  // A simultaneous read and write is resolved as a write; the read port holds.
  assign rd_en = MemRead && !MemWrite;
  assign we    = MemWrite;
  assign push  = we && hit_uart;
  // The FIFO only pops while the transmitter is idle, so full&&busy means no pop.
  assign drop  = push && fifo_full && tx_busy;

  always_ff @(posedge clk) begin
    if (we && ram_hit) mem_q[ram_idx] <= dWriteData;
  end

  always_comb begin
    rdata_mux = '0;
    if (hit_led) begin
      rdata_mux = {16'b0, led_q};
    end else if (hit_sw) begin
      rdata_mux = {16'b0, sw_sync_q};
    end else if (hit_timer) begin
      rdata_mux = timer_q;
    end else if (hit_status) begin
      rdata_mux[ST_FULL]  = fifo_full;
      rdata_mux[ST_EMPTY] = fifo_empty;
      rdata_mux[ST_BUSY]  = tx_busy;
      rdata_mux[ST_OVF]   = overflow_q;
    end else if (ram_hit) begin
      rdata_mux = mem_q[ram_idx];
    end

    rdata_d    = rd_en ? rdata_mux : rdata_q;
    led_d      = (we && hit_led) ? dWriteData[15:0] : led_q;
    timer_d    = (we && hit_timer) ? '0 : timer_q + 32'd1;
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;

    overflow_d = overflow_q;
    if (rd_en && hit_status) overflow_d = 1'b0;
    if (drop)                overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
    end
  end

  uart_tx #(
    .BAUD_DIV  (BAUD_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (dWriteData[7:0]),
    .full (fifo_full),
    .empty(fifo_empty),
    .busy (tx_busy),
    .tx   (uart_tx)
  );

  assign dReadData = rdata_q;
  assign led       = led_q;

endmodule

// File: tb/tb_mc_data_mem_io.sv
// Randomized bench for mc_data_mem_io against a behavioural model of the
// RAM, MMIO registers and 8N1 frames (BAUD_DIV = 100/25 = 4).
module tb_mc_data_mem_io;

  localparam logic [31:0] BASE     = 32'h1001_0000;
  localparam int          WORDS    = 256;
  localparam int          DIV      = 4;
  localparam int          FL       = 10 * DIV;
  localparam logic [31:0] LED_A    = 32'hFFFF_0000;
  localparam logic [31:0] SW_A     = 32'hFFFF_0004;
  localparam logic [31:0] TIMER_A  = 32'hFFFF_0008;
  localparam logic [31:0] UART_A   = 32'hFFFF_000C;
  localparam logic [31:0] STATUS_A = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dAddress = '0;
  logic [31:0] dWriteData = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] dReadData;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        uart_tx;

  int          checks = 0;
  int          failures = 0;
  int unsigned edge_n = 0;

  logic [31:0] ram_m [int];
  int          widx_q [$];
  logic [15:0] led_m;
  logic [15:0] sw_m;
  int unsigned tref;

  mc_data_mem_io #(
    .DMEM_BASE (BASE),
    .DMEM_WORDS(WORDS),
    .DMEM_INIT (""),
    .CLK_HZ    (100),
    .BAUD      (25),
    .FIFO_DEPTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dAddress  (dAddress),
    .dWriteData(dWriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .dReadData (dReadData),
    .sw        (sw),
    .led       (led),
    .uart_tx   (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dAddress = a; dWriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    @(posedge clk); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dAddress = a; MemRead = 1'b1; MemWrite = 1'b0;
    @(posedge clk); #1;
    MemRead = 1'b0;
    d = dReadData;
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_tx", uart_tx, 1'b1);
    chk("rst_led", led, 16'h0);
    chk("rst_rdata", dReadData, 32'h0);
    tref  = edge_n;
    led_m = '0;
    sw_m  = sw;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] ram_addr(input int idx);
    return BASE + 32'(idx) * 4 + 32'($urandom_range(0, 3));
  endfunction

  // Waits for a start bit, then records FL samples and compares to the ideal frame.
  task automatic frame(input logic [7:0] b, input int exp_gap, input string tag);
    int          waited;
    logic [9:0]  fr;
    logic [FL-1:0] obs, expv;
    waited = 0;
    @(negedge clk);
    while (uart_tx !== 1'b0 && waited < 500) begin
      waited++;
      @(negedge clk);
    end
    if (exp_gap >= 0) chk({tag, "_gap"}, waited, exp_gap);
    else              chk({tag, "_start"}, waited < 500, 1'b1);
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < DIV; c++) expv[k*DIV + c] = fr[k];
    obs[0] = uart_tx;
    for (int i = 1; i < FL; i++) begin
      @(negedge clk);
      obs[i] = uart_tx;
    end
    chk(tag, obs, expv);
  endtask

  initial begin
    logic [31:0] v, d, a, hold;
    logic [7:0]  bytes [10];
    logic        quiet;
    int          idx, k, op;
    int unsigned w;

    reset_pulse(3);

    // Fixed directed cases first
    wr(32'h1001_0010, 32'hDEAD_BEEF);
    ram_m[4] = 32'hDEAD_BEEF; widx_q.push_back(4);
    rd(32'h1001_0010, v); chk("ram_beef", v, 32'hDEAD_BEEF);
    d = $urandom;
    wr(32'h1001_0014, d); ram_m[5] = d; widx_q.push_back(5);
    rd(32'h1001_0017, v); chk("ram_lowbits", v, d);
    d = $urandom; wr(ram_addr(0), d); ram_m[0] = d; widx_q.push_back(0);
    d = $urandom; wr(ram_addr(WORDS-1), d); ram_m[WORDS-1] = d; widx_q.push_back(WORDS-1);

    wr(LED_A, 32'h0001_A5A5); led_m = 16'hA5A5;
    chk("led_out", led, 16'hA5A5);
    rd(LED_A, v); chk("led_rd", v, 32'h0000_A5A5);

    @(negedge clk); sw = 16'h1234;
    @(negedge clk);
    rd(SW_A, v); chk("sw_rd", v, 32'h0000_1234);
    sw_m = 16'h1234;

    wr(TIMER_A, 32'h0); w = edge_n;
    repeat (4) @(negedge clk);
    rd(TIMER_A, v); chk("timer_5", v, edge_n - w - 1);

    @(negedge clk);
    force dut.timer_q = 32'hFFFF_FFFF;
    #1;
    release dut.timer_q;
    dAddress = TIMER_A; MemRead = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0;
    chk("timer_max", dReadData, 32'hFFFF_FFFF);
    rd(TIMER_A, v); chk("timer_wrap", v, 32'h0);

    // Read+write together: write lands, read port holds
    rd(ram_addr(4), hold);
    d = $urandom;
    @(negedge clk);
    dAddress = ram_addr(5); dWriteData = d; MemRead = 1'b1; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    ram_m[5] = d;
    chk("rw_hold", dReadData, hold);
    rd(ram_addr(5), v); chk("rw_write", v, d);

    // Randomized register/RAM traffic
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          idx = (($urandom_range(0, 3) == 0) ? WORDS - 1 : $urandom_range(0, 31));
          d = $urandom; wr(ram_addr(idx), d);
          if (!ram_m.exists(idx)) widx_q.push_back(idx);
          ram_m[idx] = d;
        end
        1: begin
          idx = widx_q[$urandom_range(0, widx_q.size() - 1)];
          rd(ram_addr(idx), v); chk("ram_rd", v, ram_m[idx]);
        end
        2: begin
          d = $urandom; wr(LED_A, d); led_m = d[15:0];
          chk("led_wr", led, led_m);
        end
        3: begin
          rd(LED_A, v); chk("led_rd_r", v, {16'h0, led_m});
        end
        4: begin
          case ($urandom_range(0, 3))
            0: a = BASE - 4;
            1: a = BASE + 4 * WORDS;
            2: a = 32'hFFFF_0014;
            default: a = SW_A;
          endcase
          wr(a, $urandom);
          rd(a, v); chk("unmapped", v, (a == SW_A) ? {16'h0, sw_m} : 32'h0);
          rd(ram_addr(0), v); chk("ram_alias0", v, ram_m[0]);
          rd(ram_addr(WORDS-1), v); chk("ram_aliasN", v, ram_m[WORDS-1]);
        end
        5: begin
          @(negedge clk); sw = 16'($urandom);
          rd(SW_A, v); chk("sw_early", v, {16'h0, sw_m});
          rd(SW_A, v); chk("sw_sync", v, {16'h0, sw});
          sw_m = sw;
        end
        default: begin
          wr(TIMER_A, $urandom); w = edge_n;
          k = $urandom_range(0, 7);
          repeat (k) @(negedge clk);
          rd(TIMER_A, v); chk("timer_rnd", v, edge_n - w - 1);
        end
      endcase
    end

    // Single frame of 0x55 plus a few random bytes
    wr(UART_A, 32'h0000_0055);
    frame(8'h55, 1, "frame55");
    rd(STATUS_A, v); chk("status_idle", v, 32'h2);
    for (int i = 0; i < 3; i++) begin
      bytes[0] = 8'($urandom);
      wr(UART_A, {24'($urandom), bytes[0]});
      frame(bytes[0], 1, "frame_rnd");
    end

    // Ten back-to-back pushes: one in flight, eight queued, one dropped
    bytes[0] = 8'hFF;
    for (int i = 1; i < 10; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) wr(UART_A, {24'h0, bytes[i]});
    rd(STATUS_A, v); chk("status_ovf", v, 32'hD);
    rd(STATUS_A, v); chk("status_ovf_clr", v, 32'h5);
    frame(bytes[1], -1, "burst1");
    for (int i = 2; i < 9; i++) frame(bytes[i], 1, "burst");
    rd(STATUS_A, v); chk("status_drain", v, 32'h2);

    // Reset in the middle of the data bits
    wr(UART_A, 32'h0000_00A3);
    wr(UART_A, 32'h0000_003C);
    repeat (8) @(negedge clk);
    rd(STATUS_A, v); chk("status_busy", v, 32'h4);
    reset_pulse(1);
    rd(STATUS_A, v); chk("status_rst", v, 32'h2);
    rd(TIMER_A, v); chk("timer_rst", v, edge_n - tref - 1);
    quiet = 1'b1;
    repeat (60) begin
      @(negedge clk);
      quiet = quiet & uart_tx;
    end
    chk("rst_quiet", quiet, 1'b1);
    rd(ram_addr(4), v); chk("ram_keep", v, ram_m[4]);
    bytes[0] = 8'($urandom);
    wr(UART_A, {24'h0, bytes[0]});
    frame(bytes[0], 1, "frame_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mc_data_mem_io.md
# mc_data_mem_io

Data-side memory subsystem for the multicycle RISC-V core. It consumes the core's MEM-state data bus (dAddress, dWriteData, MemRead, MemWrite) and returns dReadData one cycle later, in time for write-back. It contains a word-addressed data RAM and a small memory-mapped I/O block: LEDs, switches, a cycle timer, and a FIFO-buffered 8N1 UART transmitter.

## Interface
- DMEM_BASE, 32'h10010000, byte base address of data RAM
- DMEM_WORDS, 1024, RAM depth in 32-bit words (power of 2)
- DMEM_INIT, "", optional $readmemh file; empty means no initialisation
- CLK_HZ, 100_000_000, clock frequency
- BAUD, 19200, UART bit rate; BAUD_DIV = CLK_HZ/BAUD (integer division)
- FIFO_DEPTH, 8, UART TX FIFO entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dAddress  in  32  byte address from core
- dWriteData  in  32  store data
- MemRead  in  1  one-cycle read strobe
- MemWrite  in  1  one-cycle write strobe
- dReadData  out  32  registered read data
- sw  in  16  asynchronous switch inputs
- led  out  16  LED register
- uart_tx  out  1  serial output, idle high

## Operation
- Address decode uses dAddress[31:2]; bits [1:0] are ignored. All accesses are full-word.
- RAM region: DMEM_BASE to DMEM_BASE+4*DMEM_WORDS-1.
- MMIO register map:
  - 0xFFFF0000 LED: R/W. Write sets led to dWriteData[15:0]. Read returns zero-extended led.
  - 0xFFFF0004 SW: read-only. Returns zero-extended 2-flop-synchronised sw. Writes are ignored.
  - 0xFFFF0008 TIMER: free-running 32-bit cycle counter that wraps at 2^32. Any write clears it to 0 on that edge. Read returns the pre-edge value.
  - 0xFFFF000C UART_TX: write pushes dWriteData[7:0] into the FIFO. Read returns 0.
  - 0xFFFF0010 STATUS: bit0 fifo_full, bit1 fifo_empty, bit2 tx_busy, bit3 overflow (sticky). All other bits are 0. A read clears overflow after returning it.
- Unmapped read returns 0. Unmapped write has no effect.
- FIFO push:
  - Accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
- UART FSM states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: drive tx low for BAUD_DIV cycles.
  - DATA: 8 bits LSB first, BAUD_DIV cycles each.
  - STOP: drive tx high for BAUD_DIV cycles, then return to IDLE.
  - tx_busy is 1 in any state other than IDLE.
- Back-to-back frames: STOP goes to IDLE for exactly one cycle before the next START.
- MemRead and MemWrite asserted together is illegal input. If it happens, the write is performed and dReadData holds its value.

## Timing
- Read latency is 1 cycle: MemRead at edge N; dReadData is valid after edge N+1 and held until the next MemRead.
- Writes take effect at the edge that ends the MemWrite cycle.
- sw reaches the SW register 2 cycles after a change.
- Frame length is 10*BAUD_DIV cycles, plus 1 IDLE cycle between frames.
- The first START begins 1 cycle after the push edge (one IDLE-pop cycle).
- Reset values: dReadData=0, led=0, uart_tx=1, timer=0, FIFO empty, overflow=0, FSM IDLE, baud counter 0.
- RAM contents are not affected by reset.
- Reset mid-frame: the FSM goes to IDLE and uart_tx=1 at the next edge. FIFO contents and the byte in flight are discarded.
- Timer is not incremented in the reset cycle. It counts 1 after the first non-reset edge.

## Structure
- Package mc_io_pkg holds:
  - MMIO address localparams
  - STATUS bit indices
  - UART state enum typedef uart_state_t {IDLE, START, DATA, STOP}
- Sub-module uart_tx contains the FIFO, baud counter and serializer. Its interface:
  - push, din[7:0]
  - full, empty, busy
  - tx
- The top level contains the decode, RAM, LED, switch synchroniser, timer, overflow flag and read mux.

## Test plan
- Store 0xDEADBEEF to 0x10010010, then load from it: dReadData=0xDEADBEEF one cycle after MemRead. Load of 0x10010014 with its low bits ignored returns that word's contents.
- Write 0x0001A5A5 to LED: led=0xA5A5. Read LED returns 0x0000A5A5. sw=0x1234 held for 3 cycles, then read SW returns 0x00001234.
- Timer:
  - Write to TIMER, then read 5 cycles later: returns 5 (±1 per documented edge rule).
  - Force the counter to 0xFFFFFFFF: the next cycle reads 0.
- Use BAUD_DIV=4 and push 0x55: uart_tx shows the sequence 0,1,0,1,0,1,0,1,0,1, each level for 4 cycles. tx_busy is 1 for 40 cycles, then STATUS=0x2.
- Push 10 bytes back-to-back while the first is transmitting:
  - 9 bytes are accepted: 1 in flight plus 8 in the FIFO.
  - Result: full=1 and overflow=1, so STATUS reads 0xD.
  - A second STATUS read returns 0x5.
- Assert rst mid-DATA: uart_tx=1 and STATUS=0x2 after the edge. A later push transmits a clean frame.
